sub_16_serial: RTL and testbench



---
 rtl/sub_16_serial_pkg.sv | 18 +
 rtl/sub_16_serial_fs.sv | 13 +
 rtl/sub_16_serial.sv | 114 +++++++++++
 tb/tb_sub_16_serial.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sub_16_serial_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encodings, default width
// and the bit-counter width helper.
package sub_16_serial_pkg;

   localparam int SUB16_WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      SUB16_IDLE = 2'd0,
      SUB16_RUN  = 2'd1,
      SUB16_DONE = 2'd2
   } state_t;

   // A 2-bit operand still needs a 1-bit counter.
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/sub_16_serial_fs.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub_16_serial.sv
// Bit-serial WIDTH-bit subtractor (out = a - b), LSB first, valid/ready on both sides.
// Optional macro SUB_16_SERIAL_SAT_EN: unsigned saturation (result forced to 0 on borrow).
//
// state      | meaning
// SUB16_IDLE | waiting for operands, in_ready=1
// SUB16_RUN  | one bit per clock through the subtractor cell
// SUB16_DONE | result held, out_valid=1 until out_ready
module sub_16_serial
   import sub_16_serial_pkg::*;
#(
   parameter int WIDTH = SUB16_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             borrow,
   output logic             zero
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state, state_n;
   logic [WIDTH-1:0] a_sh, b_sh, res, res_n;
   logic [CW-1:0]    cnt;
   logic             bor, bor_n, d;

   full_subtractor u_fs (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (bor),
      .d    (d),
      .bout (bor_n)
   );

   assign res_n = {d, res[WIDTH-1:1]};

   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         SUB16_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_n = SUB16_RUN;
         end
         SUB16_RUN: begin
            if (cnt == CNT_LAST) state_n = SUB16_DONE;
         end
         SUB16_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_n = SUB16_IDLE;
         end
         default: state_n = SUB16_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= SUB16_IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         res    <= '0;
         bor    <= 1'b0;
         cnt    <= '0;
         out    <= '0;
         borrow <= 1'b0;
         zero   <= 1'b0;
      end else begin
         state <= state_n;
         case (state)
            SUB16_IDLE: begin
               if (in_valid) begin
                  a_sh <= a;
                  b_sh <= b;
                  bor  <= 1'b0;
                  cnt  <= '0;
               end
            end
            SUB16_RUN: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               res  <= res_n;
               bor  <= bor_n;
               cnt  <= cnt + CW'(1);
               // Outputs are latched only on the last bit so they stay put through IDLE.
               if (cnt == CNT_LAST) begin
                  borrow <= bor_n;
`ifdef SUB_16_SERIAL_SAT_EN
                  if (bor_n) begin
                     out  <= '0;
                     zero <= 1'b1;
                  end else begin
                     out  <= res_n;
                     zero <= (res_n == '0);
                  end
`else
                  out  <= res_n;
                  zero <= (res_n == '0);
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sub_16_serial.sv
// Directed self-checking bench for sub_16_serial (honours SUB_16_SERIAL_SAT_EN).
module tb_sub_16_serial;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready, out_valid, borrow, zero;
   logic [W-1:0] out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] out;
      logic         bor;
      logic         zer;
   } vec_t;

   vec_t vecs[8];

   sub_16_serial #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .borrow    (borrow),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t sat_adjust(input vec_t v);
      vec_t r;
      r = v;
`ifdef SUB_16_SERIAL_SAT_EN
      if (r.bor) begin
         r.out = '0;
         r.zer = 1'b1;
      end
`endif
      return r;
   endfunction

   // Present operands at a negedge, take the acceptance edge, end on the following negedge.
   task automatic accept(input logic [W-1:0] aa, input logic [W-1:0] bb);
      @(negedge clk);
      a = aa;
      b = bb;
      in_valid = 1'b1;
      chk("in_ready_idle", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("in_ready_run", in_ready, 0);
   endtask

   // Count rising edges after the acceptance edge until out_valid, then check the result.
   task automatic wait_done(input int start, input vec_t v);
      int n;
      n = start;
      while (!out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", n, W);
      chk("out", out, v.out);
      chk("borrow", borrow, v.bor);
      chk("zero", zero, v.zer);
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
      out_ready = 1'b0;
   endtask

   initial begin
      vec_t v;
      vecs[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0};
      vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
      vecs[2] = '{16'h0001, 16'hFFFF, 16'h0002, 1'b1, 1'b0};
      vecs[3] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
      vecs[4] = '{16'hAAAA, 16'h5555, 16'h5555, 1'b0, 1'b0};
      vecs[5] = '{16'h7FFF, 16'h8000, 16'hFFFF, 1'b1, 1'b0};
      vecs[6] = '{16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0};
      vecs[7] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};

      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out", out, 0);
      chk("rst_borrow", borrow, 0);
      chk("rst_zero", zero, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         v = sat_adjust(vecs[i]);
         accept(v.a, v.b);
         wait_done(0, v);
         release_result();
      end

      // Equal operands, operand changes after acceptance, in_valid pulses in RUN and DONE.
      accept(16'hBEEF, 16'hBEEF);
      a = 16'h0000;
      b = 16'h0001;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("run_ignores_in_valid", in_ready, 0);
      wait_done(1, '{16'hBEEF, 16'hBEEF, 16'h0000, 1'b0, 1'b1});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = (i % 2 == 0);
         chk("hold_out_valid", out_valid, 1);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_out", out, 0);
         chk("hold_zero", zero, 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      release_result();
      @(negedge clk);
      chk("no_stray_accept", in_ready, 1);

      // Back-to-back: second pair held valid throughout the first operation.
      accept(16'h8000, 16'h0001);
      a = 16'hFFFF;
      b = 16'h7FFF;
      in_valid = 1'b1;
      wait_done(0, '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0});
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("b2b_idle_in_ready", in_ready, 1);
      chk("b2b_idle_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
      chk("b2b_second_accept", in_ready, 0);
      in_valid = 1'b0;
      wait_done(0, '{16'hFFFF, 16'h7FFF, 16'h8000, 1'b0, 1'b0});
      release_result();

      // Asynchronous reset 8 cycles into RUN, then a fresh operation.
      accept(16'h1234, 16'h0001);
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out", out, 0);
      chk("mid_rst_borrow", borrow, 0);
      chk("mid_rst_zero", zero, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("no_resume_out_valid", out_valid, 0);
      accept(16'h0005, 16'h0003);
      wait_done(0, '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0});
      release_result();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
